hazard_ctrl_v2: RTL and testbench
=================================

Name: hazard_ctrl_v2

Overview:
- Second-generation pipeline hazard and control unit for the 5-stage MIPS core (F/D/E/M/W).
- Generates forwarding selects and per-stage stall/flush controls. Adds instruction-bus and data-bus wait stalls, a sequenced exception flush that discards an in-flight fetch, and saturating stall/flush performance counters.
- Register-address width and counter width are parametrised. Sits beside the datapath and is driven by decode/execute/memory/writeback fields and the SRAM-like bus handshakes.

Parameters:
- REG_AW, 5, register-address width for rs/rt/rd/writeReg fields.
- CNT_W, 32, width of the stall_cnt and flush_cnt performance counters.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- rsD, rtD  in  REG_AW  decode source registers
- branchD, jrD  in  1  decode is a branch / register jump
- rsE, rtE, rdE, writeRegE  in  REG_AW  execute register fields
- regWriteE, memToRegE, div_busyE  in  1  execute write-enable, load, divider busy
- writeRegM, rdM  in  REG_AW  memory-stage destination and cp0 rd
- regWriteM, memToRegM, hilo_weM, cp0_weM  in  1  memory-stage write enables
- writeRegW  in  REG_AW  writeback destination
- regWriteW, hilo_weW  in  1  writeback write enables
- except_reqM  in  1  exception detected in M
- inst_busy  in  1  fetch request outstanding, data not yet returned
- inst_data_ok  in  1  fetch data returns this cycle
- data_busy  in  1  M-stage load/store waiting for data_ok
- forwardAE, forwardBE, forwardHiloE  out  2  10 = from M, 01 = from W, 00 = none
- forwardAD, forwardBD, forwardcp0E  out  1  decode/cp0 forward from M
- stallF, stallD, stallE, stallM, stallW  out  1  hold stage register
- flushF, flushD, flushE, flushM, flushW  out  1  bubble stage register
- pc_redirect  out  1  load exception vector into PC this cycle
- discard_fetch  out  1  drop returning fetch data
- stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- Forwarding is combinational and unchanged in meaning. Source register 0 never forwards. M has priority over W. forwardHiloE = 10 if hilo_weM, else 01 if hilo_weW. forwardcp0E = cp0_weM && rdM == rdE.
- lw_stall = memToRegE && rtE != 0 && (rsD == rtE || rtD == rtE).
- br_stall = branchD && ((regWriteE && writeRegE != 0 && writeRegE matches rsD or rtD) || (memToRegM && writeRegM matches rsD or rtD)).
- jr_stall is the same as br_stall but gated by jrD and checks rsD only.
- hz = lw_stall | br_stall | jr_stall.
- Priority, highest first (acc = except_reqM && !data_busy && state == IDLE):
  1. data_busy: stallF/D/E/M = 1, flushW = 1. except_reqM is held off until data_busy drops.
  2. acc: flushF/D/E/M/W = 1, pc_redirect = 1, all stalls 0. flush_cnt += 1. Next state is WAIT_IF if inst_busy && !inst_data_ok, else IDLE.
  3. div_busyE: stallF/D/E = 1, flushM = 1.
  4. hz: stallF/D = 1, flushE = 1.
  5. inst_busy && !inst_data_ok: stallF = 1, flushD = 1.
  6. Otherwise all stall and flush outputs are 0.
- FSM states:
  - IDLE: normal operation, priority list above applies.
  - WAIT_IF: stallF = 1 and flushD = 1 every cycle; other controls follow the list with acc forced 0. On inst_data_ok: discard_fetch = 1 that cycle, flushD = 1, next state IDLE.
  - discard_fetch is 0 in all other cycles.
- Counters:
  - stall_cnt increments every cycle stallF = 1.
  - flush_cnt increments on acc.
  - Both saturate at all-ones and never wrap.
- Reset (resetn low, asynchronous, any time including mid-WAIT_IF): state = IDLE, counters = 0, discard_fetch = 0.
- Combinational outputs then follow the inputs; with all inputs 0, every stall, flush and forward output is 0.
- Simultaneous inst_data_ok and acc: no WAIT_IF entry, because the returning word is already squashed by flushD.

Test Plan:
- Reset → all outputs 0. Then writeRegM = 3, regWriteM = 1, rsE = 3, and W also writes 3 → forwardAE = 10. Repeat with rsE = 0 → forwardAE = 00.
- Load-use: memToRegE = 1, rtE = 5, rsD = 5 → stallF = stallD = flushE = 1 for one cycle. With rtE = 0 → no stall.
- except_reqM with data_busy = 1 for 3 cycles → no pc_redirect during those cycles, stallM = 1. In the 4th cycle, data_busy = 0 → pc_redirect = 1, flushF..W = 1, flush_cnt = 1.
- except_reqM with inst_busy = 1, inst_data_ok = 0 → WAIT_IF. Hold 2 cycles with stallF = 1. Then inst_data_ok = 1 → discard_fetch = 1, flushD = 1, then IDLE.
- div_busyE for 10 cycles while hz = 1 → stallE = 1, flushM = 1, flushE = 0, stall_cnt = 10.
- CNT_W = 4, stallF held 20 cycles → stall_cnt saturates at 15. Drop resetn mid-WAIT_IF → state IDLE, counters 0 immediately.

Source files
------------

// File: rtl/hazard_ctrl_v2.sv
// hazard_ctrl_v2: forwarding, stall/flush control, exception
// sequencing around fetch, and saturating perf counters.
module hazard_ctrl_v2 #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              jrD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] rdE,
  input  logic [REG_AW-1:0] writeRegE,
  input  logic              regWriteE,
  input  logic              memToRegE,
  input  logic              div_busyE,
  input  logic [REG_AW-1:0] writeRegM,
  input  logic [REG_AW-1:0] rdM,
  input  logic              regWriteM,
  input  logic              memToRegM,
  input  logic              hilo_weM,
  input  logic              cp0_weM,
  input  logic [REG_AW-1:0] writeRegW,
  input  logic              regWriteW,
  input  logic              hilo_weW,
  input  logic              except_reqM,
  input  logic              inst_busy,
  input  logic              inst_data_ok,
  input  logic              data_busy,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic [1:0]        forwardHiloE,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic              forwardcp0E,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushF,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              pc_redirect,
  output logic              discard_fetch,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {IDLE, WAIT_IF} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             lw_stall, br_stall, jr_stall, hz;
  logic             acc;

  // Bypass selects; M beats W, r0 never forwards
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    forwardHiloE = 2'b00;
    if (rsE != '0 && regWriteM && writeRegM == rsE)
      forwardAE = 2'b10;
    else if (rsE != '0 && regWriteW && writeRegW == rsE)
      forwardAE = 2'b01;
    if (rtE != '0 && regWriteM && writeRegM == rtE)
      forwardBE = 2'b10;
    else if (rtE != '0 && regWriteW && writeRegW == rtE)
      forwardBE = 2'b01;
    if (hilo_weM)
      forwardHiloE = 2'b10;
    else if (hilo_weW)
      forwardHiloE = 2'b01;
    forwardAD = rsD != '0 && regWriteM && writeRegM == rsD;
    forwardBD = rtD != '0 && regWriteM && writeRegM == rtD;
    forwardcp0E = cp0_weM && rdM == rdE;
  end

  // Load-use and branch/jr operand hazards
  always_comb begin
    lw_stall = memToRegE && rtE != '0 &&
               (rsD == rtE || rtD == rtE);
    br_stall = branchD &&
      ((regWriteE && writeRegE != '0 &&
        (writeRegE == rsD || writeRegE == rtD)) ||
       (memToRegM &&
        (writeRegM == rsD || writeRegM == rtD)));
    jr_stall = jrD &&
      ((regWriteE && writeRegE != '0 &&
        writeRegE == rsD) ||
       (memToRegM && writeRegM == rsD));
    hz = lw_stall | br_stall | jr_stall;
  end

  // Prioritised stage controls and exception sequencing
  always_comb begin
    state_d = state_q;
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    stallW = 1'b0;
    flushF = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    pc_redirect = 1'b0;
    discard_fetch = 1'b0;
    acc = except_reqM && !data_busy && state_q == IDLE;
    if (data_busy) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (acc) begin
      flushF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
      pc_redirect = 1'b1;
    end else if (div_busyE) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (hz) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (inst_busy && !inst_data_ok) begin
      stallF = 1'b1;
      flushD = 1'b1;
    end
    if (state_q == WAIT_IF) begin
      stallF = 1'b1;
      flushD = 1'b1;
      discard_fetch = inst_data_ok;
    end
    if (acc)
      state_d = (inst_busy && !inst_data_ok) ? WAIT_IF : IDLE;
    else if (state_q == WAIT_IF && inst_data_ok)
      state_d = IDLE;
  end

  // State register and saturating perf counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (stallF && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (acc && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// tb_hazard_ctrl_v2: directed + random checks of hazard_ctrl_v2
// against a behavioural model of the control rules.
module tb_hazard_ctrl_v2;

  typedef struct packed {
    logic [1:0] fae;
    logic [1:0] fbe;
    logic [1:0] fh;
    logic       fad;
    logic       fbd;
    logic       fc;
    logic [4:0] st;
    logic [4:0] fl;
    logic       redir;
    logic       disc;
  } ctl_t;

  logic clk, resetn;
  logic [4:0] rsD, rtD, rsE, rtE, rdE, writeRegE;
  logic [4:0] writeRegM, rdM, writeRegW;
  logic branchD, jrD, regWriteE, memToRegE, div_busyE;
  logic regWriteM, memToRegM, hilo_weM, cp0_weM;
  logic regWriteW, hilo_weW, except_reqM;
  logic inst_busy, inst_data_ok, data_busy;

  logic [1:0] forwardAE, forwardBE, forwardHiloE;
  logic forwardAD, forwardBD, forwardcp0E;
  logic stallF, stallD, stallE, stallM, stallW;
  logic flushF, flushD, flushE, flushM, flushW;
  logic pc_redirect, discard_fetch;
  logic [31:0] stall_cnt, flush_cnt;

  logic [1:0] s_fae, s_fbe, s_fh;
  logic s_fad, s_fbd, s_fc;
  logic s_sF, s_sD, s_sE, s_sM, s_sW;
  logic s_fF, s_fD, s_fE, s_fM, s_fW;
  logic s_redir, s_disc;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  ctl_t vec, s_vec;
  int total = 0;
  int bad = 0;

  bit      m_wt;
  longint  m_sc, m_fc, m_ssc, m_sfc;

  hazard_ctrl_v2 #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
    .rsE(rsE), .rtE(rtE), .rdE(rdE), .writeRegE(writeRegE),
    .regWriteE(regWriteE), .memToRegE(memToRegE),
    .div_busyE(div_busyE),
    .writeRegM(writeRegM), .rdM(rdM), .regWriteM(regWriteM),
    .memToRegM(memToRegM), .hilo_weM(hilo_weM), .cp0_weM(cp0_weM),
    .writeRegW(writeRegW), .regWriteW(regWriteW),
    .hilo_weW(hilo_weW), .except_reqM(except_reqM),
    .inst_busy(inst_busy), .inst_data_ok(inst_data_ok),
    .data_busy(data_busy),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardHiloE(forwardHiloE), .forwardAD(forwardAD),
    .forwardBD(forwardBD), .forwardcp0E(forwardcp0E),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .stallM(stallM), .stallW(stallW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE),
    .flushM(flushM), .flushW(flushW),
    .pc_redirect(pc_redirect), .discard_fetch(discard_fetch),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl_v2 #(.REG_AW(5), .CNT_W(4)) dut_s (
    .clk(clk), .resetn(resetn),
    .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
    .rsE(rsE), .rtE(rtE), .rdE(rdE), .writeRegE(writeRegE),
    .regWriteE(regWriteE), .memToRegE(memToRegE),
    .div_busyE(div_busyE),
    .writeRegM(writeRegM), .rdM(rdM), .regWriteM(regWriteM),
    .memToRegM(memToRegM), .hilo_weM(hilo_weM), .cp0_weM(cp0_weM),
    .writeRegW(writeRegW), .regWriteW(regWriteW),
    .hilo_weW(hilo_weW), .except_reqM(except_reqM),
    .inst_busy(inst_busy), .inst_data_ok(inst_data_ok),
    .data_busy(data_busy),
    .forwardAE(s_fae), .forwardBE(s_fbe),
    .forwardHiloE(s_fh), .forwardAD(s_fad),
    .forwardBD(s_fbd), .forwardcp0E(s_fc),
    .stallF(s_sF), .stallD(s_sD), .stallE(s_sE),
    .stallM(s_sM), .stallW(s_sW),
    .flushF(s_fF), .flushD(s_fD), .flushE(s_fE),
    .flushM(s_fM), .flushW(s_fW),
    .pc_redirect(s_redir), .discard_fetch(s_disc),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  assign vec = {forwardAE, forwardBE, forwardHiloE,
                forwardAD, forwardBD, forwardcp0E,
                stallF, stallD, stallE, stallM, stallW,
                flushF, flushD, flushE, flushM, flushW,
                pc_redirect, discard_fetch};
  assign s_vec = {s_fae, s_fbe, s_fh, s_fad, s_fbd, s_fc,
                  s_sF, s_sD, s_sE, s_sM, s_sW,
                  s_fF, s_fD, s_fE, s_fM, s_fW,
                  s_redir, s_disc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fsel(input logic [4:0] src);
    if (src == 0) return 2'd0;
    if (regWriteM && writeRegM == src) return 2'd2;
    if (regWriteW && writeRegW == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bool_match(input logic [4:0] a,
                                input logic [4:0] b,
                                input logic [4:0] c);
  endfunction

  function automatic ctl_t model(input bit wt);
    ctl_t e;
    bit ld, br, jr, take;
    bit e_hit_s, e_hit_t, m_hit_s, m_hit_t;
    e = '0;
    e.fae = fsel(rsE);
    e.fbe = fsel(rtE);
    e.fh = hilo_weM ? 2'd2 : (hilo_weW ? 2'd1 : 2'd0);
    e.fad = (fsel(rsD) == 2'd2) || (rsD != 0 && regWriteM && writeRegM == rsD);
    e.fbd = rtD != 0 && regWriteM && writeRegM == rtD;
    e.fc = cp0_weM && (rdM == rdE);
    ld = memToRegE && rtE != 0 && (rsD == rtE || rtD == rtE);
    e_hit_s = regWriteE && writeRegE != 0 && writeRegE == rsD;
    e_hit_t = regWriteE && writeRegE != 0 && writeRegE == rtD;
    m_hit_s = memToRegM && writeRegM == rsD;
    m_hit_t = memToRegM && writeRegM == rtD;
    br = branchD && (e_hit_s || e_hit_t || m_hit_s || m_hit_t);
    jr = jrD && (e_hit_s || m_hit_s);
    take = except_reqM && !data_busy && !wt;
    if (data_busy) begin
      e.st = 5'b11110; e.fl = 5'b00001;
    end else if (take) begin
      e.fl = 5'b11111; e.redir = 1'b1;
    end else if (div_busyE) begin
      e.st = 5'b11100; e.fl = 5'b00010;
    end else if (ld || br || jr) begin
      e.st = 5'b11000; e.fl = 5'b00100;
    end else if (inst_busy && !inst_data_ok) begin
      e.st = 5'b10000; e.fl = 5'b01000;
    end
    if (wt) begin
      e.st[4] = 1'b1;
      e.fl[3] = 1'b1;
      e.disc = inst_data_ok;
    end
    return e;
  endfunction

  // reference state: fetch-wait flag and counters as plain integers
  always @(posedge clk or negedge resetn) begin
    ctl_t e;
    if (!resetn) begin
      m_wt = 0; m_sc = 0; m_fc = 0; m_ssc = 0; m_sfc = 0;
    end else begin
      e = model(m_wt);
      if (e.st[4]) begin
        m_sc = (m_sc < 64'hFFFF_FFFF) ? m_sc + 1 : m_sc;
        m_ssc = (m_ssc < 15) ? m_ssc + 1 : m_ssc;
      end
      if (e.redir) begin
        m_fc = (m_fc < 64'hFFFF_FFFF) ? m_fc + 1 : m_fc;
        m_sfc = (m_sfc < 15) ? m_sfc + 1 : m_sfc;
      end
      if (e.redir)
        m_wt = inst_busy && !inst_data_ok;
      else if (m_wt && inst_data_ok)
        m_wt = 0;
    end
  end

  always @(negedge clk) begin
    ctl_t e;
    e = model(m_wt);
    check("ctl", 64'(vec), 64'(e));
    check("ctl_s", 64'(s_vec), 64'(e));
    check("stall_cnt", 64'(stall_cnt), 64'(m_sc));
    check("flush_cnt", 64'(flush_cnt), 64'(m_fc));
    check("stall_cnt4", 64'(s_stall_cnt), 64'(m_ssc));
    check("flush_cnt4", 64'(s_flush_cnt), 64'(m_sfc));
  end

  task automatic clr();
    {rsD, rtD, rsE, rtE, rdE, writeRegE} = '0;
    {writeRegM, rdM, writeRegW} = '0;
    {branchD, jrD, regWriteE, memToRegE, div_busyE} = '0;
    {regWriteM, memToRegM, hilo_weM, cp0_weM} = '0;
    {regWriteW, hilo_weW, except_reqM} = '0;
    {inst_busy, inst_data_ok, data_busy} = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    resetn = 1'b0;
    @(negedge clk);
    check("rst_ctl", 64'(vec), 64'd0);
    check("rst_cnt", 64'(stall_cnt), 64'd0);
    nxt();
    resetn = 1'b1;

    writeRegM = 3; regWriteM = 1; rsE = 3;
    writeRegW = 3; regWriteW = 1;
    @(negedge clk);
    check("fwdAE_M", 64'(forwardAE), 64'd2);
    nxt();
    rsE = 0;
    @(negedge clk);
    check("fwdAE_r0", 64'(forwardAE), 64'd0);
    nxt();
    clr();

    memToRegE = 1; rtE = 5; rsD = 5;
    @(negedge clk);
    check("lw_stall", 64'({stallF, stallD, flushE}), 64'd7);
    nxt();
    rtE = 0;
    @(negedge clk);
    check("lw_r0", 64'({stallF, stallD, flushE}), 64'd0);
    nxt();
    clr();

    except_reqM = 1; data_busy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("exc_held", 64'({pc_redirect, stallM}), 64'd1);
      nxt();
    end
    data_busy = 0;
    @(negedge clk);
    check("exc_take", 64'({pc_redirect, flushF, flushD,
                           flushE, flushM, flushW}), 64'h3f);
    nxt();
    except_reqM = 0;
    @(negedge clk);
    check("flush_cnt1", 64'(flush_cnt), 64'd1);
    nxt();

    except_reqM = 1; inst_busy = 1; inst_data_ok = 0;
    @(negedge clk);
    check("wif_take", 64'(pc_redirect), 64'd1);
    nxt();
    except_reqM = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("wif_hold", 64'({stallF, flushD, discard_fetch}), 64'd6);
      nxt();
    end
    inst_data_ok = 1;
    @(negedge clk);
    check("wif_disc", 64'({discard_fetch, flushD}), 64'd3);
    nxt();
    inst_busy = 0;
    @(negedge clk);
    check("wif_idle", 64'({discard_fetch, stallF}), 64'd0);
    nxt();
    clr();

    resetn = 0;
    nxt();
    resetn = 1;
    div_busyE = 1; memToRegE = 1; rtE = 5; rsD = 5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("div_hz", 64'({stallE, flushM, flushE}), 64'd6);
      nxt();
    end
    clr();
    @(negedge clk);
    check("stall_cnt10", 64'(stall_cnt), 64'd10);
    check("stall_cnt4_10", 64'(s_stall_cnt), 64'd10);
    nxt();
    div_busyE = 1;
    repeat (10) nxt();
    clr();
    @(negedge clk);
    check("sat15", 64'(s_stall_cnt), 64'd15);
    check("cnt20", 64'(stall_cnt), 64'd20);
    nxt();

    except_reqM = 1; inst_busy = 1;
    nxt();
    except_reqM = 0;
    @(negedge clk);
    #2;
    resetn = 0;
    #1;
    check("rst_mid_cnt", 64'({stall_cnt, flush_cnt}), 64'd0);
    check("rst_mid_disc", 64'(discard_fetch), 64'd0);
    nxt();
    resetn = 1; inst_busy = 0; inst_data_ok = 1;
    @(negedge clk);
    check("rst_mid_idle", 64'(discard_fetch), 64'd0);
    nxt();
    clr();

    for (int n = 0; n < 3000; n++) begin
      resetn = ($urandom_range(0, 199) != 0);
      rsD = 5'($urandom_range(0, 3));
      rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3));
      rtE = 5'($urandom_range(0, 3));
      rdE = 5'($urandom_range(0, 3));
      writeRegE = 5'($urandom_range(0, 3));
      writeRegM = 5'($urandom_range(0, 3));
      rdM = 5'($urandom_range(0, 3));
      writeRegW = 5'($urandom_range(0, 3));
      branchD = ($urandom_range(0, 3) == 0);
      jrD = ($urandom_range(0, 3) == 0);
      regWriteE = 1'($urandom_range(0, 1));
      memToRegE = ($urandom_range(0, 3) == 0);
      div_busyE = ($urandom_range(0, 7) == 0);
      regWriteM = 1'($urandom_range(0, 1));
      memToRegM = ($urandom_range(0, 3) == 0);
      hilo_weM = 1'($urandom_range(0, 1));
      cp0_weM = 1'($urandom_range(0, 1));
      regWriteW = 1'($urandom_range(0, 1));
      hilo_weW = 1'($urandom_range(0, 1));
      except_reqM = ($urandom_range(0, 5) == 0);
      inst_busy = ($urandom_range(0, 2) == 0);
      inst_data_ok = ($urandom_range(0, 2) == 0);
      data_busy = ($urandom_range(0, 3) == 0);
      nxt();
    end
    clr();
    resetn = 1;
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
